pd_gen_switch_ctrl: RTL
=======================

// Module: pd_gen_switch_ctrl
// PURPOSE
//  Sequences PCIe generation (rate) changes for the packet identifier path.
//  Accepts a new-gen request, asserts hld_pd_gen to stall the identifier, and
//  waits for in-flight data to drain. It then updates the registered gen code
//  that drives the gen decoder, lets it settle, and releases the hold.
//  Sits between the LTSSM/rate logic and the gen control/valid-lane decoder.
// PARAMETERS
//  DRAIN_CYCLES   4    idle cycles required after pipe_busy falls, before switching (0 = skip)
//  SETTLE_CYCLES  2    cycles hold stays high after gen update (0 = skip)
//  BUSY_TIMEOUT   64   max cycles in HOLD waiting for pipe_busy=0 before abort (>=1)
//  MAX_GEN        3'd4 highest legal gen code (0=Gen1 .. 4=Gen5)
// PORTS
//  clk            in   1  clock
//  rst            in   1  asynchronous reset, active-high
//  req_valid      in   1  gen-change request strobe
//  req_gen        in   3  requested gen code
//  req_ready      out  1  1 = request accepted this cycle if req_valid
//  pipe_busy      in   1  1 = identifier pipeline has data in flight
//  gen            out  3  registered gen code to gen decoder
//  hld_pd_gen     out  1  1 = hold/stall the packet identifier
//  change_done    out  1  1-cycle pulse: change completed (or same-gen no-op)
//  change_err     out  1  1-cycle pulse: illegal gen or busy timeout
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, gen=3'b000, hld_pd_gen=0, req_ready=1,
//   change_done=0, change_err=0, counters=0, pending gen=0. All outputs registered.
//  FSM: IDLE -> HOLD -> DRAIN -> SWITCH -> SETTLE -> IDLE.
//  IDLE: req_ready=1. On req_valid at edge T:
//   - req_gen > MAX_GEN: change_err=1 for cycle T+1, stay IDLE, gen unchanged.
//   - req_gen == gen: change_done=1 for cycle T+1, stay IDLE, no hold.
//   - otherwise: latch req_gen into pending; HOLD from T+1; hld_pd_gen=1 from T+1.
//  req_ready=0 in all non-IDLE states; req_valid is ignored (not queued) there.
//  HOLD: busy counter increments each cycle pipe_busy=1. Exit to DRAIN on the
//   first cycle sampled with pipe_busy=0. If counter reaches BUSY_TIMEOUT:
//   abort -> IDLE, hld_pd_gen=0 and change_err=1 in the next cycle, gen unchanged.
//  DRAIN: counts DRAIN_CYCLES cycles, then SWITCH (DRAIN_CYCLES=0: HOLD->SWITCH).
//   pipe_busy rising in DRAIN returns to HOLD; drain count clears, busy count kept.
//  SWITCH: one cycle; gen <= pending at its exit edge; then SETTLE.
//  SETTLE: SETTLE_CYCLES cycles, then IDLE (SETTLE_CYCLES=0: SWITCH->IDLE).
//  Completion: first IDLE cycle has hld_pd_gen=0, change_done=1, req_ready=1.
//  Hold length with pipe_busy=0 throughout = 1 + DRAIN_CYCLES + 1 + SETTLE_CYCLES.
//  hld_pd_gen=1 in exactly HOLD/DRAIN/SWITCH/SETTLE; never glitches within a change.
//  change_done and change_err are never asserted in the same cycle.
//  Counters are sized $clog2(max(param)+1) and saturate; no wrap.
//  Reset mid-change: immediate return to reset values; gen reverts to 3'b000.
// TESTING
//  1 Reset, req gen=2, pipe_busy=0 -> hold high 8 cycles (defaults), gen=2, done pulse.
//  2 Req gen=0 while gen=0 -> change_done next cycle, hld_pd_gen stays 0.
//  3 Req gen=5 (>MAX_GEN) -> change_err 1 cycle, gen unchanged, no hold.
//  4 pipe_busy=1 for 10 cycles after accept -> DRAIN starts after busy falls, gen updated.
//  5 pipe_busy stuck 1 -> abort after 64 HOLD cycles, change_err, gen unchanged.
//  6 rst asserted in DRAIN -> gen=0, hld_pd_gen=0, req_ready=1 immediately.

Source files
------------

// File: rtl/pd_gen_switch_ctrl.sv
// Gen-change sequencer for the packet identifier path: holds the identifier,
// waits for the pipeline to drain, updates the gen code, settles, then releases.
module pd_gen_switch_ctrl #(
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned BUSY_TIMEOUT  = 64,
    parameter logic [2:0]  MAX_GEN       = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_gen,
    output logic       req_ready,
    input  logic       pipe_busy,
    output logic [2:0] gen,
    output logic       hld_pd_gen,
    output logic       change_done,
    output logic       change_err
);

    // Zero-valued parameters still need a 1-bit counter to stay legal.
    localparam int unsigned DRAIN_MAX  = (DRAIN_CYCLES  > 0) ? DRAIN_CYCLES  : 1;
    localparam int unsigned SETTLE_MAX = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
    localparam int unsigned BUSY_MAX   = (BUSY_TIMEOUT  > 0) ? BUSY_TIMEOUT  : 1;

    localparam int unsigned DW = $clog2(DRAIN_MAX + 1);
    localparam int unsigned SW = $clog2(SETTLE_MAX + 1);
    localparam int unsigned BW = $clog2(BUSY_MAX + 1);

    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_MAX - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_MAX - 1);
    localparam logic [BW-1:0] BUSY_LAST   = BW'(BUSY_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_DRAIN,
        S_SWITCH,
        S_SETTLE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_gen;
    logic [2:0]    r_pending;
    logic          r_hld;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic [BW-1:0] r_busy_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic [SW-1:0] r_settle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gen        <= '0;
            r_pending    <= '0;
            r_hld        <= 1'b0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy_cnt   <= '0;
            r_drain_cnt  <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_gen > MAX_GEN) begin
                            r_err <= 1'b1;
                        end else if (req_gen == r_gen) begin
                            r_done <= 1'b1;
                        end else begin
                            r_pending    <= req_gen;
                            r_busy_cnt   <= '0;
                            r_drain_cnt  <= '0;
                            r_settle_cnt <= '0;
                            r_state      <= S_HOLD;
                            r_hld        <= 1'b1;
                            r_ready      <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (pipe_busy) begin
                        if (r_busy_cnt == BUSY_LAST) begin
                            r_state    <= S_IDLE;
                            r_hld      <= 1'b0;
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_busy_cnt <= '0;
                        end else begin
                            r_busy_cnt <= r_busy_cnt + 1'b1;
                        end
                    end else if (DRAIN_CYCLES == 0) begin
                        r_state <= S_SWITCH;
                    end else begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end

                // Busy count is kept across a DRAIN->HOLD bounce so the timeout
                // covers the whole change, not just the latest busy burst.
                S_DRAIN: begin
                    if (pipe_busy) begin
                        r_state     <= S_HOLD;
                        r_drain_cnt <= '0;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_SWITCH;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end

                S_SWITCH: begin
                    r_gen <= r_pending;
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= S_IDLE;
                        r_hld   <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end

                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= S_IDLE;
                        r_hld   <= 1'b0;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_hld   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign gen         = r_gen;
    assign hld_pd_gen  = r_hld;
    assign req_ready   = r_ready;
    assign change_done = r_done;
    assign change_err  = r_err;

endmodule
